mmul_arbiter: RTL and testbench
===============================

MMUL_ARBITER -- requirements
Module: mmul_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 40: the maximum number of RUN cycles allowed before the job is aborted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: per-requester job request.
REQ-005 The block SHALL have port req_ready, output, 2 bits: per-requester job-accept strobe.
REQ-006 The block SHALL have ports req0_mat_a, req0_mat_b, req1_mat_a, req1_mat_b, inputs, 72 bits each: 3x3 signed 8-bit operands; element (r,c) sits at bits (r*3+c)*8 +: 8.
REQ-007 The block SHALL have port rsp_valid, output, 2 bits: per-requester result valid.
REQ-008 The block SHALL have port rsp_ready, input, 2 bits: per-requester result accept.
REQ-009 The block SHALL have port rsp_mat, output, 72 bits: result matrix, shared by both requesters.
REQ-010 The block SHALL have port rsp_err, output, 1 bit: the job timed out, and rsp_mat is undefined.
REQ-011 The block SHALL have port eng_reset, output, 1 bit: active-high load/clear for the matmul engine.
REQ-012 The block SHALL have port eng_enable, output, 1 bit: engine step enable.
REQ-013 The block SHALL have ports eng_mat_a and eng_mat_b, outputs, 72 bits each: operands driven to the engine.
REQ-014 The block SHALL have port eng_result, input, 72 bits: engine result.
REQ-015 The block SHALL have port eng_done, input, 1 bit: engine completion flag.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RUN, DRAIN and RESP, with one job in flight at a time.
REQ-018 In IDLE with any req_valid bit set, the block SHALL choose a winner round-robin: a lone requester wins; if both are valid, the requester not granted last wins.
REQ-019 In that IDLE cycle, the block SHALL assert req_ready for the winner only, latch the winner's operands and owner index, and go to LOAD.
REQ-020 req_ready MAY depend combinationally on req_valid; requesters SHALL hold req_valid and their operands stable until req_ready is seen.
REQ-021 In LOAD, the block SHALL assert eng_reset for exactly 1 cycle with eng_mat_a and eng_mat_b already driven from the latched operands, then go to RUN.
REQ-022 In RUN, eng_enable SHALL be 1, and a cycle counter SHALL count from 0.
REQ-023 In RUN, eng_done=1 SHALL cause a transition to DRAIN.
REQ-024 In RUN, if the counter reaches TIMEOUT-1 without eng_done, the block SHALL set the error flag and go to RESP.
REQ-025 In DRAIN, eng_enable SHALL be 0 for 1 cycle, because the engine registers its result one cycle after done; at the end of DRAIN the block SHALL capture eng_result into the rsp_mat register and go to RESP.
REQ-026 In RESP, rsp_valid SHALL be asserted for the owner only, with rsp_mat and rsp_err held stable until rsp_ready[owner] is 1.
REQ-027 When rsp_ready[owner] is 1 in RESP, the block SHALL clear rsp_err, update last-grant to the owner, and return to IDLE.
REQ-028 The block SHALL NOT accept a new request in the same cycle as a RESP handshake; the minimum gap between jobs is 1 IDLE cycle.
REQ-029 The block SHALL not accept requests in any state other than IDLE; req_valid outside IDLE SHALL be ignored, with no loss of the pending request.
REQ-030 rsp_ready for a non-owner, or any rsp_ready outside RESP, SHALL be ignored.
REQ-031 A late eng_done arriving after a timeout, or in any state other than RUN, SHALL be ignored.
REQ-032 Operands and results SHALL pass through unmodified; the block performs no arithmetic.

Reset
REQ-033 While reset_n=0 at a clk edge, the state SHALL go to IDLE; req_ready, rsp_valid, rsp_err, eng_enable and busy SHALL be 0; rsp_mat, eng_mat_a and eng_mat_b SHALL be 0; the counter SHALL be 0; last-grant SHALL be 1, so requester 0 wins the first tie.
REQ-034 eng_reset SHALL be 1 whenever reset_n=0, so that a reset in the middle of a job also clears the engine.
REQ-035 A job in flight at reset SHALL be dropped with no response.

Structure
REQ-036 Shared package mmul_pkg SHALL hold MAT_W=72, ELEM_W=8, N=3, the FSM state enum, and the default TIMEOUT.
REQ-037 The round-robin choice SHALL be in sub-module rr_arb2 (inputs: 2-bit valid and last-grant; outputs: one-hot grant).

Verification
REQ-038 The bench SHALL cover: req0 with A=identity (bytes 0,4,8 = 8'h01, others 0) and B bytes 0..8 = 8'h01..8'h09 -> rsp_valid[0], rsp_mat=B, rsp_err=0, and rsp_valid[1] never asserted.
REQ-039 The bench SHALL cover: both req_valid rise in the same cycle right after reset -> req0 is served first, then req1; a second simultaneous pair -> req1 is served first, then req0.
REQ-040 The bench SHALL cover: A all 8'h03, B all 8'h02 -> every rsp_mat byte is 8'h12; A and B all 8'h10 -> every byte is 8'h00 (8-bit wrap is owned by the engine and passed through unmodified).
REQ-041 The bench SHALL cover: an engine model that never asserts eng_done with TIMEOUT=40 -> rsp_valid exactly 40 RUN cycles after eng_enable rises, rsp_err=1, and the next job completes normally.
REQ-042 The bench SHALL cover: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_mat stay stable and req_ready stays 0; on rsp_ready=1 the block returns to IDLE.
REQ-043 The bench SHALL cover: reset_n=0 for 1 cycle in the middle of RUN -> eng_reset=1 that cycle, then all outputs are at reset values, no response is issued, and the next request is served correctly.

Source files
------------

// File: rtl/mmul_pkg.sv
// Shared types and constants for the matmul job arbiter.
// Matrices are 3x3 of 8-bit elements, element (r,c) at bits (r*3+c)*8 +: 8.
package mmul_pkg;

  localparam int MAT_W       = 72;
  localparam int ELEM_W      = 8;
  localparam int N           = 3;
  localparam int TIMEOUT_DEF = 40;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2
  import mmul_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  assign o_grant = (i_valid == 2'b11) ? owner_onehot(~i_last_grant) : i_valid;

endmodule

// File: rtl/mmul_arbiter.sv
// Arbitrates two requesters onto one external 3x3 matmul engine, one job
// in flight, with a RUN-cycle timeout that reports an error response.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches the winner's operands
// LOAD  | eng_reset pulse loads the latched operands into the engine
// RUN   | engine stepping; ends on eng_done or on timeout
// DRAIN | one idle cycle while the engine registers its result
// RESP  | result held for the owner until rsp_ready[owner]
module mmul_arbiter
  import mmul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [MAT_W-1:0] req0_mat_a,
  input  logic [MAT_W-1:0] req0_mat_b,
  input  logic [MAT_W-1:0] req1_mat_a,
  input  logic [MAT_W-1:0] req1_mat_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [MAT_W-1:0] rsp_mat,
  output logic             rsp_err,
  output logic             eng_reset,
  output logic             eng_enable,
  output logic [MAT_W-1:0] eng_mat_a,
  output logic [MAT_W-1:0] eng_mat_b,
  input  logic [MAT_W-1:0] eng_result,
  input  logic             eng_done,
  output logic             busy
);

  localparam int CNT_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

  state_t           r_state;
  logic             r_last;
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [MAT_W-1:0] r_mat_a;
  logic [MAT_W-1:0] r_mat_b;
  logic [MAT_W-1:0] r_rsp_mat;
  logic             r_err;
  logic [1:0]       r_rsp_valid;
  logic             r_eng_reset;
  logic             r_eng_enable;
  logic             r_busy;
  logic [1:0]       w_grant;

  rr_arb2 u_rr_arb2 (
    .i_valid      (req_valid),
    .i_last_grant (r_last),
    .o_grant      (w_grant)
  );

  assign req_ready  = (reset_n && r_state == IDLE) ? w_grant : 2'b00;
  // Reset also clears the engine, so a job aborted mid-flight leaves nothing behind.
  assign eng_reset  = ~reset_n | r_eng_reset;
  assign eng_enable = r_eng_enable;
  assign eng_mat_a  = r_mat_a;
  assign eng_mat_b  = r_mat_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_mat    = r_rsp_mat;
  assign rsp_err    = r_err;
  assign busy       = r_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_mat_a      <= '0;
      r_mat_b      <= '0;
      r_rsp_mat    <= '0;
      r_err        <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_eng_reset  <= 1'b0;
      r_eng_enable <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_owner     <= w_grant[1];
            r_mat_a     <= w_grant[1] ? req1_mat_a : req0_mat_a;
            r_mat_b     <= w_grant[1] ? req1_mat_b : req0_mat_b;
            r_eng_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          r_eng_reset  <= 1'b0;
          r_eng_enable <= 1'b1;
          r_cnt        <= '0;
          r_state      <= RUN;
        end
        RUN: begin
          // eng_done wins over a timeout landing on the same cycle.
          if (eng_done) begin
            r_eng_enable <= 1'b0;
            r_state      <= DRAIN;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_eng_enable <= 1'b0;
            r_err        <= 1'b1;
            r_rsp_valid  <= owner_onehot(r_owner);
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          r_rsp_mat   <= eng_result;
          r_rsp_valid <= owner_onehot(r_owner);
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[r_owner]) begin
            r_rsp_valid <= 2'b00;
            r_err       <= 1'b0;
            r_last      <= r_owner;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmul_arbiter.sv
// Directed bench for mmul_arbiter with a small behavioural matmul engine
// that finishes four enabled cycles after load (or never, when hung).
module tb_mmul_arbiter;

  localparam logic [71:0] M_ID    = 72'h01_00_00_00_01_00_00_00_01;
  localparam logic [71:0] M_SEQ   = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] M_R1    = 72'h19_18_17_16_15_14_13_12_11;
  localparam logic [71:0] M_R2    = 72'h29_28_27_26_25_24_23_22_21;
  localparam logic [71:0] M_R3    = 72'h39_38_37_36_35_34_33_32_31;
  localparam logic [71:0] M_ALL3  = {9{8'h03}};
  localparam logic [71:0] M_ALL2  = {9{8'h02}};
  localparam logic [71:0] M_ALL12 = {9{8'h12}};
  localparam logic [71:0] M_ALL10 = {9{8'h10}};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [71:0] req0_mat_a, req0_mat_b, req1_mat_a, req1_mat_b;
  logic [71:0] rsp_mat, eng_mat_a, eng_mat_b, eng_result;
  logic        rsp_err, eng_reset, eng_enable, eng_done, busy;

  int n_chk  = 0;
  int n_pass = 0;

  mmul_arbiter #(.TIMEOUT(40)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_mat_a (req0_mat_a),
    .req0_mat_b (req0_mat_b),
    .req1_mat_a (req1_mat_a),
    .req1_mat_b (req1_mat_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_mat    (rsp_mat),
    .rsp_err    (rsp_err),
    .eng_reset  (eng_reset),
    .eng_enable (eng_enable),
    .eng_mat_a  (eng_mat_a),
    .eng_mat_b  (eng_mat_b),
    .eng_result (eng_result),
    .eng_done   (eng_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Engine model: 8-bit wrapping product, result registered one cycle after done.
  logic [71:0] e_a, e_b, e_res;
  logic        e_done;
  int          e_cnt;
  bit          e_hang = 0;

  function automatic logic [71:0] mat_mul(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] m;
    logic [7:0]  s;
    m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        s = '0;
        for (int k = 0; k < 3; k++)
          s = s + 8'(a[(r*3+k)*8 +: 8] * b[(k*3+c)*8 +: 8]);
        m[(r*3+c)*8 +: 8] = s;
      end
    return m;
  endfunction

  always @(posedge clk) begin
    if (eng_reset) begin
      e_a    <= eng_mat_a;
      e_b    <= eng_mat_b;
      e_cnt  <= 0;
      e_done <= 1'b0;
      e_res  <= '0;
    end else begin
      e_done <= 1'b0;
      if (eng_enable) begin
        e_cnt <= e_cnt + 1;
        if (e_cnt == 3 && !e_hang) e_done <= 1'b1;
      end
      if (e_done) e_res <= mat_mul(e_a, e_b);
    end
  end

  assign eng_done   = e_done;
  assign eng_result = e_res;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; returns the first req_ready pattern seen and drops that winner's request.
  task automatic wait_grant(input string tag, output logic [1:0] seen);
    bit hit = 0;
    seen = 2'b00;
    for (int i = 0; i < 100 && !hit; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        hit  = 1;
        seen = req_ready;
      end else @(negedge clk);
    end
    chk({tag, " grant seen"}, 72'(hit), 72'd1);
    if (hit) begin
      @(negedge clk);
      req_valid[seen[1]] = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int who, input string tag);
    for (int i = 0; i < 200 && rsp_valid == 2'b00; i++) @(negedge clk);
    chk({tag, " rsp_valid"}, 72'(rsp_valid), (who == 1) ? 72'd2 : 72'd1);
  endtask

  task automatic ack(input int who, input string tag);
    rsp_ready[who] = 1'b1;
    @(negedge clk);
    rsp_ready[who] = 1'b0;
    chk({tag, " idle busy"}, 72'(busy), 72'd0);
    chk({tag, " idle rsp_valid"}, 72'(rsp_valid), 72'd0);
    chk({tag, " idle rsp_err"}, 72'(rsp_err), 72'd0);
  endtask

  task automatic get_rsp(input int who, input logic [71:0] exp_mat, input logic exp_err, input string tag);
    wait_rsp(who, tag);
    chk({tag, " rsp_err"}, 72'(rsp_err), 72'(exp_err));
    if (!exp_err) chk({tag, " rsp_mat"}, rsp_mat, exp_mat);
    ack(who, tag);
  endtask

  task automatic set_req(input int who, input logic [71:0] a, input logic [71:0] b);
    if (who == 0) begin req0_mat_a = a; req0_mat_b = b; end
    else          begin req1_mat_a = a; req1_mat_b = b; end
    req_valid[who] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] seen;
    int n_en, n_bad;

    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_mat_a = '0; req0_mat_b = '0; req1_mat_a = '0; req1_mat_b = '0;
    repeat (3) @(negedge clk);
    chk("rst eng_reset", 72'(eng_reset), 72'd1);
    chk("rst busy", 72'(busy), 72'd0);
    chk("rst rsp_valid", 72'(rsp_valid), 72'd0);
    chk("rst eng_enable", 72'(eng_enable), 72'd0);
    chk("rst rsp_err", 72'(rsp_err), 72'd0);
    chk("rst rsp_mat", rsp_mat, 72'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post rst eng_reset", 72'(eng_reset), 72'd0);

    // First tie after reset: requester 0, then requester 1
    set_req(0, M_ID, M_SEQ);
    set_req(1, M_ID, M_R1);
    wait_grant("pair1 a", seen);
    chk("pair1 first winner", 72'(seen), 72'd1);
    get_rsp(0, M_SEQ, 1'b0, "pair1 job0");
    wait_grant("pair1 b", seen);
    chk("pair1 second winner", 72'(seen), 72'd2);
    get_rsp(1, M_R1, 1'b0, "pair1 job1");

    // Lone requester 0, identity * B = B
    set_req(0, M_ID, M_SEQ);
    wait_grant("lone0", seen);
    chk("lone0 winner", 72'(seen), 72'd1);
    get_rsp(0, M_SEQ, 1'b0, "lone0");

    // Tie after requester 0 was served last: requester 1 first
    set_req(0, M_ID, M_R2);
    set_req(1, M_ID, M_R3);
    wait_grant("pair2 a", seen);
    chk("pair2 first winner", 72'(seen), 72'd2);
    get_rsp(1, M_R3, 1'b0, "pair2 job1");
    wait_grant("pair2 b", seen);
    chk("pair2 second winner", 72'(seen), 72'd1);
    get_rsp(0, M_R2, 1'b0, "pair2 job0");

    // Pass-through of engine arithmetic, including 8-bit wrap
    set_req(1, M_ALL3, M_ALL2);
    wait_grant("arith12", seen);
    get_rsp(1, M_ALL12, 1'b0, "arith12");
    set_req(0, M_ALL10, M_ALL10);
    wait_grant("arith wrap", seen);
    get_rsp(0, 72'd0, 1'b0, "arith wrap");

    // Hung engine: timeout after exactly 40 enabled RUN cycles
    e_hang = 1;
    set_req(0, M_ID, M_SEQ);
    wait_grant("timeout", seen);
    n_en = 0;
    for (int i = 0; i < 200 && rsp_valid == 2'b00; i++) begin
      if (eng_enable) n_en++;
      @(negedge clk);
    end
    chk("timeout run cycles", 72'(n_en), 72'd40);
    chk("timeout enable low at rsp", 72'(eng_enable), 72'd0);
    get_rsp(0, '0, 1'b1, "timeout");
    e_hang = 0;
    set_req(0, M_ALL3, M_ALL2);
    wait_grant("after timeout", seen);
    get_rsp(0, M_ALL12, 1'b0, "after timeout");

    // Response stall with requester 1 waiting
    set_req(0, M_ID, M_R2);
    wait_grant("stall", seen);
    wait_rsp(0, "stall");
    set_req(1, M_ID, M_R1);
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid !== 2'b01 || rsp_mat !== M_R2 || req_ready !== 2'b00) n_bad++;
      @(negedge clk);
    end
    chk("stall stable cycles bad", 72'(n_bad), 72'd0);
    chk("stall rsp_mat", rsp_mat, M_R2);
    ack(0, "stall");
    wait_grant("stall pending", seen);
    chk("stall pending winner", 72'(seen), 72'd2);
    get_rsp(1, M_R1, 1'b0, "stall pending");

    // Reset in the middle of RUN drops the job
    set_req(0, M_ALL3, M_ALL2);
    wait_grant("midrst", seen);
    for (int i = 0; i < 20 && !eng_enable; i++) @(negedge clk);
    chk("midrst in run", 72'(eng_enable), 72'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst eng_reset", 72'(eng_reset), 72'd1);
    @(negedge clk);
    chk("midrst busy", 72'(busy), 72'd0);
    chk("midrst eng_enable", 72'(eng_enable), 72'd0);
    chk("midrst rsp_valid", 72'(rsp_valid), 72'd0);
    chk("midrst rsp_mat", rsp_mat, 72'd0);
    chk("midrst eng_mat_a", eng_mat_a, 72'd0);
    chk("midrst req_ready", 72'(req_ready), 72'd0);
    reset_n = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || busy) n_bad++;
    end
    chk("midrst no response", 72'(n_bad), 72'd0);
    set_req(1, M_ID, M_R3);
    wait_grant("post midrst", seen);
    chk("post midrst winner", 72'(seen), 72'd2);
    get_rsp(1, M_R3, 1'b0, "post midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
